// File: rtl/ptw_pkg.sv
// Shared types and constants for the two-level page-table walker.
package ptw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L2_REQ,
    L2_WAIT,
    DONE
  } state_e;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PPN_W  = 20;
  localparam int unsigned PERM_W = 3;
  localparam int unsigned VPN_W  = 10;

  localparam logic [ADDR_W-1:0] ROOT_BASE_DEFAULT = 32'h0000_0400;

endpackage

// File: rtl/pte_decode.sv
// Classifies one PTE word as leaf, pointer or fault and extracts ppn/perm.
module pte_decode
  import ptw_pkg::*;
(
  input  logic [31:0]       pte_i,
  input  logic              level2_i,
  input  logic [VPN_W-1:0]  vpn0_i,
  output logic              is_leaf_o,
  output logic              is_ptr_o,
  output logic              fault_o,
  output logic [PPN_W-1:0]  ppn_o,
  output logic [PERM_W-1:0] perm_o
);

  logic v, r, w, x, any_perm, w_only;
  logic unused_bits;

  assign v        = pte_i[PTE_V];
  assign r        = pte_i[PTE_R];
  assign w        = pte_i[PTE_W];
  assign x        = pte_i[PTE_X];
  assign any_perm = r | w | x;
  assign w_only   = w & ~r;

  assign is_ptr_o  = v & ~any_perm;
  assign is_leaf_o = v & any_perm & ~w_only;
  // A pointer found at the last level has nowhere to go.
  assign fault_o   = ~v | w_only | (level2_i & is_ptr_o);

  assign ppn_o  = !is_leaf_o ? '0 :
                  level2_i   ? pte_i[31:12] : {pte_i[31:22], vpn0_i};
  assign perm_o = is_leaf_o ? {x, w, r} : '0;

  assign unused_bits = ^pte_i[11:4];

endmodule

// File: rtl/page_table_walker.sv
// Two-level page-table walker: one walk in flight, sole memory requester.
module page_table_walker
  import ptw_pkg::*;
#(
  parameter logic [31:0] ROOT_BASE = ROOT_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              walk_req_valid_i,
  output logic              walk_req_ready_o,
  input  logic [31:0]       walk_vaddr_i,
  output logic              walk_resp_valid_o,
  input  logic              walk_resp_ready_i,
  output logic [PPN_W-1:0]  walk_ppn_o,
  output logic [PERM_W-1:0] walk_perm_o,
  output logic              walk_super_o,
  output logic              walk_fault_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_resp_valid_i,
  output logic              mem_resp_ready_o,
  input  logic [31:0]       mem_data_i
);

  state_e              state_q;
  logic [VPN_W-1:0]    vpn0_q;
  logic                req_ready_q, resp_valid_q, super_q, fault_q;
  logic [PPN_W-1:0]    ppn_q;
  logic [PERM_W-1:0]   perm_q;
  logic                mem_req_valid_q, mem_resp_ready_q;
  logic [31:0]         mem_addr_q;

  logic                dec_leaf, dec_ptr, dec_fault;
  logic [PPN_W-1:0]    dec_ppn;
  logic [PERM_W-1:0]   dec_perm;
  logic [31:0]         l1_addr_d, l2_addr_d;
  logic                unused_vaddr;

  assign l1_addr_d = ROOT_BASE + {20'd0, walk_vaddr_i[31:22], 2'b00};
  assign l2_addr_d = {mem_data_i[31:10], 10'd0} + {20'd0, vpn0_q, 2'b00};
  assign unused_vaddr = ^walk_vaddr_i[11:0];

  pte_decode u_pte_decode (
    .pte_i     (mem_data_i),
    .level2_i  (state_q == L2_WAIT),
    .vpn0_i    (vpn0_q),
    .is_leaf_o (dec_leaf),
    .is_ptr_o  (dec_ptr),
    .fault_o   (dec_fault),
    .ppn_o     (dec_ppn),
    .perm_o    (dec_perm)
  );

  // Walk FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      vpn0_q           <= '0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      ppn_q            <= '0;
      perm_q           <= '0;
      super_q          <= 1'b0;
      fault_q          <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      mem_addr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (walk_req_valid_i && req_ready_q) begin
            req_ready_q     <= 1'b0;
            vpn0_q          <= walk_vaddr_i[21:12];
            mem_addr_q      <= l1_addr_d;
            mem_req_valid_q <= 1'b1;
            state_q         <= L1_REQ;
          end
        end
        L1_REQ, L2_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            state_q          <= (state_q == L1_REQ) ? L1_WAIT : L2_WAIT;
          end
        end
        L1_WAIT, L2_WAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_q <= 1'b0;
            if (state_q == L1_WAIT && dec_ptr) begin
              mem_addr_q      <= l2_addr_d;
              mem_req_valid_q <= 1'b1;
              state_q         <= L2_REQ;
            end else begin
              ppn_q        <= dec_ppn;
              perm_q       <= dec_perm;
              super_q      <= dec_leaf && (state_q == L1_WAIT);
              fault_q      <= dec_fault;
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          if (walk_resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign walk_req_ready_o  = req_ready_q;
  assign walk_resp_valid_o = resp_valid_q;
  assign walk_ppn_o        = ppn_q;
  assign walk_perm_o       = perm_q;
  assign walk_super_o      = super_q;
  assign walk_fault_o      = fault_q;
  assign mem_req_valid_o   = mem_req_valid_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_resp_ready_o  = mem_resp_ready_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Randomized bench for page_table_walker with a memory responder and a translation model.
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        walk_req_valid_i, walk_req_ready_o;
  logic [31:0] walk_vaddr_i;
  logic        walk_resp_valid_o, walk_resp_ready_i;
  logic [19:0] walk_ppn_o;
  logic [2:0]  walk_perm_o;
  logic        walk_super_o, walk_fault_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i, mem_resp_ready_o;
  logic [31:0] mem_data_i;

  page_table_walker dut (
    .clk               (clk),
    .rst               (rst),
    .walk_req_valid_i  (walk_req_valid_i),
    .walk_req_ready_o  (walk_req_ready_o),
    .walk_vaddr_i      (walk_vaddr_i),
    .walk_resp_valid_o (walk_resp_valid_o),
    .walk_resp_ready_i (walk_resp_ready_i),
    .walk_ppn_o        (walk_ppn_o),
    .walk_perm_o       (walk_perm_o),
    .walk_super_o      (walk_super_o),
    .walk_fault_o      (walk_fault_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_ready_o  (mem_resp_ready_o),
    .mem_data_i        (mem_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic [31:0] exp_reads[$];
  logic [19:0] exp_ppn;
  logic [2:0]  exp_perm;
  bit          exp_super, exp_fault;
  bit          exp_valid = 0;
  bit          busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_pte();
    logic [31:0] base;
    int k;
    base = $urandom;
    k = $urandom_range(0, 5);
    if (k == 0) return 32'h0;
    if (k == 1) return {base[31:10], 10'h001};
    return {base[31:4], 3'($urandom_range(1, 7)), (k != 5)};
  endfunction

  // Translation straight from the page-table rules.
  task automatic model(input logic [31:0] va);
    logic [31:0] a, p;
    bit v, r, w, x;
    exp_reads.delete();
    exp_ppn = 0; exp_perm = 0; exp_super = 0; exp_fault = 0;
    a = 32'h400 + 32'(va[31:22]) * 4;
    for (int lvl = 1; lvl <= 2; lvl++) begin
      exp_reads.push_back(a);
      p = rd(a);
      v = p[0]; r = p[1]; w = p[2]; x = p[3];
      if (!v || (w && !r)) begin exp_fault = 1; return; end
      if (r || w || x) begin
        exp_perm = {x, w, r};
        if (lvl == 1) begin
          exp_super = 1;
          exp_ppn = 20'((p >> 22) * 1024 + 32'(va[21:12]));
        end else begin
          exp_ppn = 20'(p >> 12);
        end
        return;
      end
      if (lvl == 2) begin exp_fault = 1; return; end
      a = (p >> 10) * 1024 + 32'(va[21:12]) * 4;
    end
  endtask

  // Memory responder: random request acceptance and 0..3 cycle read latency.
  bit          req_hs_pend = 0, resp_hs_pend = 0, have_req = 0;
  logic [31:0] req_addr, hs_addr;
  int          lat;
  initial begin
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_data_i = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_data_i = 0;
        req_hs_pend = 0; resp_hs_pend = 0; have_req = 0;
      end else begin
        if (resp_hs_pend) mem_resp_valid_i = 0;
        if (req_hs_pend) begin
          have_req = 1; req_addr = hs_addr; lat = $urandom_range(0, 3);
        end
        if (have_req && !mem_resp_valid_i) begin
          if (lat == 0) begin
            mem_resp_valid_i = 1; mem_data_i = rd(req_addr); have_req = 0;
          end else lat--;
        end
        mem_req_ready_i = !have_req && !mem_resp_valid_i && ($urandom_range(0, 3) != 0);
        req_hs_pend = mem_req_valid_o && mem_req_ready_i;
        hs_addr = mem_addr_o;
        if (req_hs_pend) rd_log.push_back(mem_addr_o);
        resp_hs_pend = mem_resp_valid_i && mem_resp_ready_o;
      end
    end
  end

  // Compare process: every cycle the result is presented, and no accept while busy.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (walk_resp_valid_o) begin
        if (!exp_valid) chk("unexpected_resp", 32'(walk_resp_valid_o), 32'd0);
        else begin
          chk("ppn", 32'(walk_ppn_o), 32'(exp_ppn));
          chk("perm", 32'(walk_perm_o), 32'(exp_perm));
          chk("super", 32'(walk_super_o), 32'(exp_super));
          chk("fault", 32'(walk_fault_o), 32'(exp_fault));
        end
      end
      if (busy) chk("req_ready_busy", 32'(walk_req_ready_o), 32'd0);
    end
  end

  task automatic wait_accept(output bit ok);
    int n = 0;
    while (!walk_req_ready_o && n < 50) begin @(negedge clk); n++; end
    ok = walk_req_ready_o;
    if (!ok) begin chk("accept_timeout", 32'd0, 32'd1); walk_req_valid_i = 0; end
  endtask

  task automatic do_walk(input logic [31:0] va, input int hold, input bit lit,
                         input logic [19:0] l_ppn, input logic [2:0] l_perm,
                         input bit l_sup, input bit l_flt, input int l_reads);
    int n;
    bit ok;
    model(va);
    @(negedge clk);
    walk_req_valid_i = 1; walk_vaddr_i = va;
    wait_accept(ok);
    if (!ok) return;
    @(posedge clk); #1;
    walk_req_valid_i = 0; walk_vaddr_i = $urandom; busy = 1; exp_valid = 1;
    rd_log.delete();
    @(negedge clk);
    n = 0;
    while (!walk_resp_valid_o && n < 200) begin @(negedge clk); n++; end
    if (!walk_resp_valid_o) begin
      chk("resp_timeout", 32'd0, 32'd1); busy = 0; exp_valid = 0; return;
    end
    if (lit) begin
      chk("lit_ppn", 32'(walk_ppn_o), 32'(l_ppn));
      chk("lit_perm", 32'(walk_perm_o), 32'(l_perm));
      chk("lit_super", 32'(walk_super_o), 32'(l_sup));
      chk("lit_fault", 32'(walk_fault_o), 32'(l_flt));
      chk("lit_reads", 32'(rd_log.size()), 32'(l_reads));
    end
    chk("num_reads", 32'(rd_log.size()), 32'(exp_reads.size()));
    for (int i = 0; i < exp_reads.size() && i < rd_log.size(); i++)
      chk("read_addr", rd_log[i], exp_reads[i]);
    repeat (hold) @(negedge clk);
    walk_resp_ready_i = 1;
    @(posedge clk); #1;
    walk_resp_ready_i = 0; busy = 0; exp_valid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(walk_req_ready_o), 32'd0);
    chk({tag, "_resp_valid"}, 32'(walk_resp_valid_o), 32'd0);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid_o), 32'd0);
    chk({tag, "_mem_resp_ready"}, 32'(mem_resp_ready_o), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_result"}, {7'd0, walk_ppn_o, walk_perm_o, walk_super_o, walk_fault_o}, 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    logic [31:0] va;
    rst = 1; walk_req_valid_i = 0; walk_vaddr_i = 0; walk_resp_ready_i = 0;
    mem[32'h400] = 32'h0000_0801;
    mem[32'h404] = 32'h1234_0007;
    mem[32'h408] = 32'h0000_0000;
    mem[32'h40C] = 32'h0000_0C01;
    mem[32'h410] = 32'h0000_0005;
    mem[32'h414] = 32'hABC0_000B;
    mem[32'h800] = 32'h1000_000F;
    mem[32'h804] = 32'h1100_000F;
    mem[32'h808] = 32'h1200_0007;
    mem[32'h80C] = 32'h0000_0000;
    for (int a = 32'h810; a < 32'h1000; a += 4) mem[32'(a)] = rand_pte();

    #1 rst = 0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1;

    do_walk(32'h0000_0000, 0, 1, 20'h10000, 3'b111, 0, 0, 2);
    do_walk(32'h0000_2000, 1, 1, 20'h12000, 3'b011, 0, 0, 2);
    do_walk(32'h0040_0000, 0, 1, 20'h12000, 3'b011, 1, 0, 1);
    do_walk(32'h0080_0000, 0, 1, 20'h00000, 3'b000, 0, 1, 1);
    do_walk(32'h0000_3000, 0, 1, 20'h00000, 3'b000, 0, 1, 2);
    do_walk(32'h0000_1000, 5, 1, 20'h11000, 3'b111, 0, 0, 2);
    do_walk(32'h0100_0000, 2, 1, 20'h00000, 3'b000, 0, 1, 1);

    // Abort a walk while waiting for the level-1 read.
    @(negedge clk);
    walk_req_valid_i = 1; walk_vaddr_i = 32'h0;
    wait_accept(ok);
    if (ok) begin
      @(posedge clk); #1 walk_req_valid_i = 0;
      n = 0;
      @(negedge clk);
      while (!mem_resp_ready_o && n < 50) begin @(negedge clk); n++; end
      chk("reach_l1_wait", 32'(mem_resp_ready_o), 32'd1);
      #2 rst = 0;
      #1 check_all_zero("midwalk_reset");
      repeat (2) @(negedge clk);
      check_all_zero("held_reset");
      rst = 1;
    end
    do_walk(32'h0000_0000, 0, 1, 20'h10000, 3'b111, 0, 0, 2);

    for (int i = 0; i < 60; i++) begin
      va = {10'($urandom_range(0, 5)), 10'($urandom_range(0, 1023)), 12'($urandom)};
      do_walk(va, $urandom_range(0, 3), 0, 20'h0, 3'b0, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
